// File: rtl/tinyqv_qspi_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tinyqv_qspi_instr_fetch                                      |
// | Description : TinyQV instruction-side QSPI continuous-read fetcher that    |
// |               streams 16-bit halfwords to the CPU fetch port.              |
// |               Optional macro QSPI_LATE_SAMPLE_EN: sample flash data at the |
// |               end of the following L phase instead of the H phase.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tinyqv_qspi_instr_fetch #(
  parameter int DUMMY_NIBBLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:1] instr_addr,
  input  logic        instr_fetch_restart,
  input  logic        instr_fetch_stall,
  input  logic        fetch_hold,
  output logic        instr_fetch_started,
  output logic        instr_fetch_stopped,
  output logic [15:0] instr_data,
  output logic        instr_ready,
  output logic        spi_cs_n,
  output logic        spi_clk_out,
  output logic [3:0]  spi_data_out,
  output logic [3:0]  spi_data_oe,
  input  logic [3:0]  spi_data_in
);

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_MODE  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_PAUSE = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] addr_q;
  logic [11:0] shift_q;
  logic [15:0] data_q;
  logic        ready_q;
  logic        started_q;
  logic        stopped_q;

  logic        start_w;
  logic        take_now_w;
  logic        last_now_w;
  logic        take_w;
  logic        last_w;

  assign start_w    = (state_q == S_IDLE) && instr_fetch_restart && !fetch_hold;
  assign take_now_w = (state_q == S_DATA) && phase_q;
  assign last_now_w = take_now_w && (cnt_q == 4'd3);

`ifdef QSPI_LATE_SAMPLE_EN
  logic take_pend_q;
  logic last_pend_q;

  // The pending sample survives a state change so the final nibble of a
  // halfword is still captured when the transaction ends at that boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      take_pend_q <= 1'b0;
      last_pend_q <= 1'b0;
    end else begin
      take_pend_q <= take_now_w;
      last_pend_q <= last_now_w;
    end
  end

  assign take_w = take_pend_q;
  assign last_w = last_pend_q;
`else
  assign take_w = take_now_w;
  assign last_w = last_now_w;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_w) state_d = S_ADDR;
      end
      S_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            state_d = S_MODE;
            cnt_d   = '0;
          end
        end
        if (instr_fetch_restart) state_d = S_GAP;
      end
      S_MODE: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_DUMMY;
            cnt_d   = '0;
          end
        end
        if (instr_fetch_restart) state_d = S_GAP;
      end
      S_DUMMY: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == DUMMY_LAST) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        if (instr_fetch_restart) state_d = S_GAP;
      end
      S_DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 4'd1;
          // Halfword boundary: restart beats hold beats stall.
          if (cnt_q == 4'd3) begin
            cnt_d = '0;
            if (fetch_hold)             state_d = S_GAP;
            else if (instr_fetch_stall) state_d = S_PAUSE;
          end
        end
        if (instr_fetch_restart) state_d = S_GAP;
      end
      S_PAUSE: begin
        cnt_d = '0;
        if (!instr_fetch_stall) state_d = S_DATA;
        if (instr_fetch_restart || fetch_hold) state_d = S_GAP;
      end
      S_GAP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      started_q <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      started_q <= start_w;
      stopped_q <= (state_d == S_GAP) && (state_q != S_GAP);
      ready_q   <= last_w;
      if (start_w) begin
        addr_q <= {instr_addr, 1'b0};
      end else if ((state_q == S_ADDR) && phase_q) begin
        addr_q <= {addr_q[19:0], 4'h0};
      end
      // Nibbles arrive as [7:4],[3:0],[15:12],[11:8]; reorder on the last one.
      if (take_w) begin
        if (last_w) begin
          data_q <= {shift_q[3:0], spi_data_in, shift_q[11:8], shift_q[7:4]};
        end else begin
          shift_q <= {shift_q[7:0], spi_data_in};
        end
      end
    end
  end

  always_comb begin
    spi_cs_n     = 1'b1;
    spi_clk_out  = 1'b0;
    spi_data_out = 4'h0;
    spi_data_oe  = 4'h0;
    case (state_q)
      S_ADDR: begin
        spi_cs_n     = 1'b0;
        spi_clk_out  = phase_q;
        spi_data_out = addr_q[23:20];
        spi_data_oe  = 4'hF;
      end
      S_MODE: begin
        spi_cs_n     = 1'b0;
        spi_clk_out  = phase_q;
        spi_data_out = cnt_q[0] ? 4'h0 : 4'hA;
        spi_data_oe  = 4'hF;
      end
      S_DUMMY, S_DATA: begin
        spi_cs_n    = 1'b0;
        spi_clk_out = phase_q;
      end
      S_PAUSE: begin
        spi_cs_n = 1'b0;
      end
      default: begin
        spi_cs_n = 1'b1;
      end
    endcase
  end

  assign instr_fetch_started = started_q;
  assign instr_fetch_stopped = stopped_q;
  assign instr_data          = data_q;
  assign instr_ready         = ready_q;

endmodule
`default_nettype wire
